// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read, single-write register file with post-reset clear sequencer
// Storage has no per-entry reset; a CLEAR pass zeroes one entry per cycle before writes are accepted.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_READ-1:0][AW-1:0]      i_readAddress,
  output logic [N_READ-1:0][XLEN-1:0]    o_readData,
  input  logic                           i_writeEnable,
  input  logic [AW-1:0]                  i_writeAddress,
  input  logic [XLEN-1:0]                i_writeData,
  output logic                           o_ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] mem [NUM_REGS];
  logic            clr_fire;
  logic            wr_fire;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NUM_REGS - 1)) state_d = RUN;
      end
      RUN: begin
        clr_idx_d = clr_idx_q;
      end
      default: state_d = CLEAR;
    endcase
  end

  // A write is only real when it will land in storage; bypass follows the same condition.
  assign clr_fire = (state_q == CLEAR) && !i_rst;
  assign wr_fire  = (state_q == RUN) && !i_rst && i_writeEnable &&
                    !((ZERO_REG != 0) && (i_writeAddress == '0));

  always_ff @(posedge i_clk) begin
    if (clr_fire) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_fire) begin
      mem[i_writeAddress] <= i_writeData;
    end
  end

  always_comb begin
    for (int p = 0; p < N_READ; p++) begin
      o_readData[p] = '0;
      if (state_q == RUN) begin
        if ((ZERO_REG != 0) && (i_readAddress[p] == '0)) begin
          o_readData[p] = '0;
        end else if ((BYPASS != 0) && wr_fire && (i_writeAddress == i_readAddress[p])) begin
          o_readData[p] = i_writeData;
        end else begin
          o_readData[p] = mem[i_readAddress[p]];
        end
      end
    end
  end

  assign o_ready = (state_q == RUN);

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport
// Two configurations share stimulus: A (ZERO_REG=1, BYPASS=1) and B (ZERO_REG=0, BYPASS=0).
module tb_regfile_multiport;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [1:0][4:0]   ra;
  logic [1:0][31:0]  rd_a, rd_b;
  logic              we;
  logic [4:0]        wa;
  logic [31:0]       wd;
  logic              rdy_a, rdy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .N_READ(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_readAddress(ra), .o_readData(rd_a),
    .i_writeEnable(we), .i_writeAddress(wa), .i_writeData(wd), .o_ready(rdy_a)
  );

  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .N_READ(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_readAddress(ra), .o_readData(rd_b),
    .i_writeEnable(we), .i_writeAddress(wa), .i_writeData(wd), .o_ready(rdy_b)
  );

  // Reference model: contents are all-zero once ready; writes before ready are simply lost.
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  bit          m_ready;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    if (!m_ready) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    if (we && wa == addr) return wd;
    return m_a[addr];
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] addr);
    if (!m_ready) return 32'h0;
    return m_b[addr];
  endfunction

  task automatic model_update();
    if (i_rst) begin
      m_cnt   = 0;
      m_ready = 0;
      for (int i = 0; i < 32; i++) begin
        m_a[i] = 32'h0;
        m_b[i] = 32'h0;
      end
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) m_ready = 1;
    end else if (we) begin
      if (wa != 5'd0) m_a[wa] = wd;
      m_b[wa] = wd;
    end
  endtask

  // Called one time unit after a posedge: check comb outputs mid-cycle, then advance one clock.
  task automatic tick();
    #2;
    chk("ready_a", {31'h0, rdy_a}, {31'h0, m_ready});
    chk("ready_b", {31'h0, rdy_b}, {31'h0, m_ready});
    chk("rd_a0", rd_a[0], exp_a(ra[0]));
    chk("rd_a1", rd_a[1], exp_a(ra[1]));
    chk("rd_b0", rd_b[0], exp_b(ra[0]));
    chk("rd_b1", rd_b[1], exp_b(ra[1]));
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; ra[0] = r0; ra[1] = r1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy_a && n < 200) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  r0, r1;
    logic [31:0] ea0, ea1, eb0, eb1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd6, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    tbl[4] = '{1'b1, 5'd7, 32'h1,        5'd7, 5'd7, 32'h1, 32'h1, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 5'd7, 32'h2,        5'd7, 5'd5, 32'h2, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 32'h2, 32'h0, 32'h2, 32'hFFFFFFFF};

    i_rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge i_clk);
    model_update();
    #1;

    // Reset held 3 cycles, then the clear pass takes exactly 32 cycles
    tick();
    tick();
    i_rst = 1'b0;
    wait_ready(n);
    chk("clear_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      chk("post_clear0", rd_a[0], 32'h0);
      chk("post_clear1", rd_b[1], 32'h0);
      tick();
    end

    for (int k = 0; k < 7; k++) begin
      drive(tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].r0, tbl[k].r1);
      #1;
      chk($sformatf("tbl%0d_a0", k), rd_a[0], tbl[k].ea0);
      chk($sformatf("tbl%0d_a1", k), rd_a[1], tbl[k].ea1);
      chk($sformatf("tbl%0d_b0", k), rd_b[0], tbl[k].eb0);
      chk($sformatf("tbl%0d_b1", k), rd_b[1], tbl[k].eb1);
      tick();
    end

    // Write attempted during CLEAR is dropped
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c == 10) drive(1'b1, 5'd3, 32'h1234, 5'd3, 5'd3);
      else         drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    chk("clr_write_rdy", {31'h0, rdy_a}, 32'h1);
    chk("clr_write_a", rd_a[0], 32'h0);
    chk("clr_write_b", rd_b[0], 32'h0);
    tick();

    // Reset mid-clear restarts the full 32-cycle pass
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    wait_ready(n);
    chk("restart_len", n, 32);

    // Reset in RUN discards contents
    drive(1'b1, 5'd9, 32'hA5A5, 5'd9, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    chk("x9_written", rd_b[0], 32'hA5A5);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    wait_ready(n);
    chk("run_rst_len", n, 32);
    chk("x9_cleared_a", rd_a[0], 32'h0);
    chk("x9_cleared_b", rd_b[1], 32'h0);

    // Random traffic with occasional resets
    for (int it = 0; it < 600; it++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      i_rst = ($urandom_range(0, 199) == 0);
      drive(i_rst ? 1'b0 : 1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
      tick();
    end
    i_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
